flag_window_monitor: RTL and testbench
======================================

Name: flag_window_monitor

Overview:
- Downstream consumer of the sequence-detector FSM's outputs: detect flag F and state vector S[2:0].
- Counts rising edges of F inside fixed-length observation windows and reports the per-window count, the last state seen at an event, and a threshold alarm.
- Used as the observation and self-check stage that sits after the detector in the lab's datapath.

Parameters:
- WINDOW, 16, window length in clock cycles (>=2)
- THRESH, 3, alarm when window event count >= THRESH (1..2^CNT_W-1)
- CNT_W, 8, width of event counter and COUNT output

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- F  input  1  detect flag from upstream FSM
- S  input  3  upstream FSM state vector
- EN  input  1  enable monitoring; low forces IDLE
- ALARM  output  1  registered; last completed window met THRESH
- COUNT  output  CNT_W  registered; event count of last completed window
- LAST_S  output  3  registered; S captured at most recent counted edge
- WIN_DONE  output  1  registered one-cycle pulse at window completion

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). All outputs and state are registers.
- RESET=1 at posedge: state=IDLE, timer=0, cnt=0, F_d=0, ALARM=0, COUNT=0, LAST_S=3'b000, WIN_DONE=0. RESET has priority over every other event, including mid-window.
- Edge detect: F_d<=F every cycle, in all states. edge = F & ~F_d.
  - F held high counts once only.
  - F already high on entry to RUN does not count.
- FSM states: IDLE and RUN.
- IDLE:
  - cnt and timer held at 0. WIN_DONE=0. Edges ignored.
  - EN=1 at posedge -> RUN with timer=0, cnt=0. The first RUN cycle is window cycle 0.
- RUN, every cycle:
  - If edge: cnt<=sat(cnt+1) and LAST_S<=S. Saturation is at 2^CNT_W-1, with no wrap.
  - timer<=timer+1.
- RUN at timer==WINDOW-1 (window completes):
  - final = sat(cnt + edge), so an edge on the last cycle is included.
  - COUNT<=final. ALARM<=(final>=THRESH). WIN_DONE<=1 for exactly one cycle.
  - cnt<=0, timer<=0. State stays RUN and back-to-back windows start with no gap cycle.
- WIN_DONE is 0 on all other cycles.
- ALARM and COUNT hold their values between completions. Each is updated only at window completion, or ALARM is cleared by an EN drop or RESET.
- EN=0 in RUN at posedge:
  - Next state IDLE. The partial window is discarded: cnt=0, timer=0, no WIN_DONE.
  - ALARM<=0. COUNT and LAST_S hold.
- Simultaneous EN=0 and timer==WINDOW-1: EN wins, so the window is not reported and ALARM<=0.
- Latency: window results are visible on outputs the cycle after the posedge that samples timer==WINDOW-1. WIN_DONE and COUNT are aligned.
- Timer width is clog2(WINDOW). Comparisons are unsigned.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=1'b0, RUN=1'b1)
  - default WINDOW/THRESH/CNT_W constants
  - S width constant (3), shared with the detector FSM.
- One natural sub-module: rise_edge_det (registers F, outputs edge pulse; synchronous active-high RESET clears the register).
- Saturating counter and window timer stay inline.

Test Plan:
- Reset: RESET=1 for 2 cycles with F=1, EN=1 -> ALARM=0, COUNT=0, LAST_S=000, WIN_DONE=0. RUN entered on the cycle after RESET falls.
- Threshold hit: EN=1; three 1-cycle F pulses at window cycles 2, 6, 10 with S=101 on the last -> at completion of cycle 15: WIN_DONE=1 for 1 cycle, COUNT=3, ALARM=1, LAST_S=101.
- Below threshold: next window one pulse at cycle 15 (last cycle), S=011 -> COUNT=1, ALARM=0, LAST_S=011, WIN_DONE pulses exactly 16 cycles after the previous one.
- Held flag / saturation: F rises at cycle 0 and stays high the whole window -> COUNT=1. With CNT_W=2 and F toggling every cycle (8 edges) -> COUNT=3, ALARM=1.
- EN drop mid-window: after 2 pulses drop EN at cycle 9 -> no WIN_DONE, ALARM=0, COUNT keeps previous value. Re-raise EN -> fresh window counts from 0.
- RESET mid-window: after 2 pulses assert RESET at cycle 5 with EN held 1 -> all outputs 0. First WIN_DONE occurs 16 cycles after RUN re-entry, not from the original start.

Source files
------------

// File: rtl/flag_window_monitor_pkg.sv
// Shared types and defaults for the flag window monitor and the upstream
// sequence detector it observes.
package flag_window_monitor_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      RUN  = ST_RUN
   } state_t;

   localparam int DEF_WINDOW = 16;
   localparam int DEF_THRESH = 3;
   localparam int DEF_CNT_W  = 8;

   // Width of the detector state vector, common to detector and monitor.
   localparam int S_W = 3;

endpackage

// File: rtl/flag_window_monitor_rise_edge_det.sv
// Registers the incoming flag and flags the cycle on which it goes 0 -> 1.
module rise_edge_det (
   input  logic CLK,
   input  logic RESET,
   input  logic d,
   output logic rise
);
   logic d_q;

   always_ff @(posedge CLK) begin
      if (RESET) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/flag_window_monitor.sv
// Counts rising edges of F over back-to-back windows of WINDOW cycles and
// reports the count, a threshold alarm and the S seen at the latest edge.
//
// state | meaning
// IDLE  | monitoring off; counter cleared, timer parked at full load
// RUN   | window in progress; timer holds cycles remaining, window ends at 0
module flag_window_monitor
   import flag_window_monitor_pkg::*;
#(
   parameter int WINDOW = DEF_WINDOW,
   parameter int THRESH = DEF_THRESH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             F,
   input  logic [S_W-1:0]   S,
   input  logic             EN,
   output logic             ALARM,
   output logic [CNT_W-1:0] COUNT,
   output logic [S_W-1:0]   LAST_S,
   output logic             WIN_DONE
);
   localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] count_d;
   logic [S_W-1:0]   last_s_d;
   logic             alarm_d, win_done_d;
   logic             f_rise;

   rise_edge_det u_rise (
      .CLK   (CLK),
      .RESET (RESET),
      .d     (F),
      .rise  (f_rise)
   );

   // Saturating increment; also used as the final count so a last-cycle edge counts.
   assign cnt_inc = (f_rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      cnt_d      = cnt_q;
      count_d    = COUNT;
      alarm_d    = ALARM;
      last_s_d   = LAST_S;
      win_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tmr_d = TMR_LOAD;
            if (EN) state_d = RUN;
         end
         RUN: begin
            if (!EN) begin
               // Partial window is dropped without a report.
               state_d = IDLE;
               cnt_d   = '0;
               tmr_d   = TMR_LOAD;
               alarm_d = 1'b0;
            end else begin
               if (f_rise) last_s_d = S;
               if (tmr_q == '0) begin
                  count_d    = cnt_inc;
                  alarm_d    = (cnt_inc >= THRESH_V);
                  win_done_d = 1'b1;
                  cnt_d      = '0;
                  tmr_d      = TMR_LOAD;
               end else begin
                  cnt_d = cnt_inc;
                  tmr_d = tmr_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         tmr_q    <= TMR_LOAD;
         cnt_q    <= '0;
         COUNT    <= '0;
         ALARM    <= 1'b0;
         LAST_S   <= '0;
         WIN_DONE <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         cnt_q    <= cnt_d;
         COUNT    <= count_d;
         ALARM    <= alarm_d;
         LAST_S   <= last_s_d;
         WIN_DONE <= win_done_d;
      end
   end

endmodule

// File: tb/tb_flag_window_monitor.sv
// Bench for flag_window_monitor: directed test-plan scenarios plus random
// traffic, two instances (default width and a 2-bit saturating counter).
module tb_flag_window_monitor;
   localparam int WINDOW = 16;
   localparam int THRESH = 3;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       F = 1'b0;
   logic [2:0] S = 3'd0;
   logic       EN = 1'b0;

   logic       alarm_a, done_a, alarm_b, done_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic [2:0] last_a, last_b;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   flag_window_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(8)) dut_a (
      .CLK(CLK), .RESET(RESET), .F(F), .S(S), .EN(EN),
      .ALARM(alarm_a), .COUNT(count_a), .LAST_S(last_a), .WIN_DONE(done_a)
   );

   flag_window_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(2)) dut_b (
      .CLK(CLK), .RESET(RESET), .F(F), .S(S), .EN(EN),
      .ALARM(alarm_b), .COUNT(count_b), .LAST_S(last_b), .WIN_DONE(done_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a window is the WINDOW cycles after entry; the result is
   // the number of 0->1 transitions of F seen in it, clipped to the counter max.
   int   cyc = 0;
   bit   m_valid = 0;
   bit   running = 0;
   int   win_end = 0;
   int   events = 0;
   logic prev_f = 1'b0;
   int   m_count [2];
   bit   m_alarm [2];
   bit   m_done;
   int   m_last;
   int   cmax [2] = '{255, 3};

   always @(posedge CLK) begin
      cyc++;
      m_done = 0;
      if (RESET) begin
         m_valid = 1;
         running = 0;
         events  = 0;
         m_last  = 0;
         for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_alarm[i] = 0;
         end
      end else if (!running) begin
         if (EN) begin
            running = 1;
            events  = 0;
            win_end = cyc + WINDOW;
         end
      end else if (!EN) begin
         running = 0;
         for (int i = 0; i < 2; i++) m_alarm[i] = 0;
      end else begin
         if (F && !prev_f) begin
            events++;
            m_last = int'(S);
         end
         if (cyc == win_end) begin
            m_done = 1;
            for (int i = 0; i < 2; i++) begin
               m_count[i] = (events > cmax[i]) ? cmax[i] : events;
               m_alarm[i] = (m_count[i] >= THRESH);
            end
            events  = 0;
            win_end = cyc + WINDOW;
         end
      end
      prev_f = RESET ? 1'b0 : F;
   end

   always @(negedge CLK) begin
      if (m_valid) begin
         chk("model_alarm_a", 32'(alarm_a), 32'(m_alarm[0]));
         chk("model_count_a", 32'(count_a), 32'(m_count[0]));
         chk("model_last_a",  32'(last_a),  32'(m_last));
         chk("model_done_a",  32'(done_a),  32'(m_done));
         chk("model_alarm_b", 32'(alarm_b), 32'(m_alarm[1]));
         chk("model_count_b", 32'(count_b), 32'(m_count[1]));
         chk("model_last_b",  32'(last_b),  32'(m_last));
         chk("model_done_b",  32'(done_b),  32'(m_done));
      end
   end

   task automatic step(input logic r, input logic e, input logic f, input logic [2:0] s);
      RESET = r;
      EN    = e;
      F     = f;
      S     = s;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_outs(input string tag, input int alarm, input int count_v,
                           input int last_v, input int done);
      chk({tag, "_alarm"}, 32'(alarm_a), 32'(alarm));
      chk({tag, "_count"}, 32'(count_a), 32'(count_v));
      chk({tag, "_last"},  32'(last_a),  32'(last_v));
      chk({tag, "_done"},  32'(done_a),  32'(done));
   endtask

   initial begin
      int done_seen;
      logic r, e, f;

      // Reset with F and EN already high.
      step(1, 1, 1, 3'd7);
      step(1, 1, 1, 3'd7);
      chk_outs("reset", 0, 0, 0, 0);
      step(0, 1, 0, 0);

      // Threshold hit: pulses at window cycles 2, 6, 10.
      for (int c = 0; c < WINDOW; c++)
         step(0, 1, (c == 2 || c == 6 || c == 10), (c == 10) ? 3'b101 : 3'b000);
      chk_outs("thresh_hit", 1, 3, 5, 1);

      // Below threshold, single edge on the last cycle.
      for (int c = 0; c < WINDOW; c++) begin
         step(0, 1, (c == 15), 3'b011);
         if (c == 14) chk("below_no_early_done", 32'(done_a), 32'd0);
      end
      chk_outs("below", 0, 1, 3, 1);

      // F held high: one edge only.
      for (int c = 0; c < WINDOW; c++) step(0, 1, (c != 0), 3'b010);
      chk_outs("held", 0, 1, 2, 1);

      // F toggling: 8 edges, 2-bit instance saturates at 3.
      for (int c = 0; c < WINDOW; c++) step(0, 1, c[0], 3'b100);
      chk_outs("toggle", 1, 8, 4, 1);
      chk("sat_count_b", 32'(count_b), 32'd3);
      chk("sat_alarm_b", 32'(alarm_b), 32'd1);

      // EN drop at cycle 9 after two pulses.
      for (int c = 0; c < 9; c++) step(0, 1, (c == 1 || c == 3), 3'b110);
      step(0, 0, 0, 0);
      chk_outs("en_drop", 0, 8, 6, 0);
      for (int c = 0; c < 4; c++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int c = 0; c < WINDOW; c++) step(0, 1, (c == 4), 3'b001);
      chk_outs("en_resume", 0, 1, 1, 1);

      // RESET at cycle 5 with EN held.
      for (int c = 0; c < 5; c++) step(0, 1, (c == 1 || c == 3), 3'b111);
      step(1, 1, 0, 0);
      chk_outs("mid_reset", 0, 0, 0, 0);
      step(0, 1, 0, 0);
      done_seen = 0;
      for (int c = 0; c < WINDOW - 1; c++) begin
         step(0, 1, 0, 0);
         if (done_a) done_seen++;
      end
      chk("mid_reset_no_early_done", 32'(done_seen), 32'd0);
      step(0, 1, 0, 0);
      chk_outs("mid_reset_window", 0, 0, 0, 1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 149) == 0);
         e = ($urandom_range(0, 59) != 0);
         f = ($urandom_range(0, 2) == 0);
         step(r, e, f, 3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
